decode_stage: RTL and testbench

Instruction-decode stage that directly feeds the 32x32 register file. It takes fetched instructions through a valid/ready handshake and drives the register-file read addresses combinationally. It registers the decoded control word, write destination and immediate into an ID/EX pipeline register for the execute stage. It also detects load-use hazards and inserts bubbles, and it honours a flush from branch resolution.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/decode_ctrl.sv | 71 +++++++
 rtl/decode_stage.sv | 103 ++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU op encodings and the
// control word carried through the ID/EX register.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        alu_op_t     alu_op;
        logic        illegal;
        logic [4:0]  write_register;
        logic [31:0] immediate;
    } ctrl_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction-to-control-word decode. With DECODE_ILLEGAL_TRAP_EN
// defined, unknown opcodes/functs are flagged as illegal; otherwise they decode as NOPs.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        rs_used,
    output logic        rt_used
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [5:0] op;
    logic [5:0] funct;
    logic       known;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    assign rs_used = (op != OP_J);
    assign rt_used = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);

    always_comb begin
        ctrl                = '0;
        known               = 1'b1;
        ctrl.alu_op         = ALU_ADD;
        ctrl.write_register = (op == OP_RTYPE) ? instr[15:11] : instr[20:16];
        ctrl.immediate      = (op == OP_J) ? {4'b0000, instr[25:0], 2'b00}
                                           : sign_ext16(instr[15:0]);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
                    default: known = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: known = 1'b0;
        endcase
        // $zero is never written, whatever the instruction claims.
        if (ctrl.write_register == 5'd0) ctrl.reg_write = 1'b0;
        ctrl.illegal = TRAP_EN && !known;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: valid/ready intake, register-file address drive, load-use bubble
// insertion, flush and the ID/EX register. DECODE_ILLEGAL_TRAP_EN enables exIllegal.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_WIDTH-1:0]     inInstr,
    input  logic [PC_WIDTH-1:0]       inPc,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] readRegister1,
    output logic [REG_ADDR_WIDTH-1:0] readRegister2,
    output logic                      exValid,
    input  logic                      exReady,
    output logic [REG_ADDR_WIDTH-1:0] exWriteRegister,
    output logic                      exRegWrite,
    output logic                      exMemRead,
    output logic                      exMemWrite,
    output logic                      exAluSrc,
    output logic                      exBranch,
    output logic                      exJump,
    output logic [3:0]                exAluOp,
    output logic [DATA_WIDTH-1:0]     exImmediate,
    output logic [PC_WIDTH-1:0]       exPc,
    output logic                      exIllegal
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the same-side valid.
    ctrl_t               dec;
    logic                rs_used;
    logic                rt_used;
    ctrl_t               ex_ctrl;
    logic                ex_valid;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                adv;
    logic                hazard;

    decode_ctrl u_ctrl (
        .instr   (inInstr),
        .ctrl    (dec),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    assign readRegister1 = inInstr[25:21];
    assign readRegister2 = inInstr[20:16];

    assign adv = !ex_valid || exReady;

    // A load in ID/EX cannot forward to a consumer still in decode.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_ctrl.mem_read && ex_ctrl.write_register != 5'd0) begin
            hazard = (rs_used && inInstr[25:21] == ex_ctrl.write_register) ||
                     (rt_used && inInstr[20:16] == ex_ctrl.write_register);
        end
    end

    assign inReady = adv && !hazard && !flush;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
        end else if (adv) begin
            if (inValid && !hazard) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= dec;
                ex_pc    <= inPc;
            end else begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_pc    <= '0;
            end
        end
    end

    assign exValid         = ex_valid;
    assign exWriteRegister = ex_ctrl.write_register;
    assign exRegWrite      = ex_ctrl.reg_write;
    assign exMemRead       = ex_ctrl.mem_read;
    assign exMemWrite      = ex_ctrl.mem_write;
    assign exAluSrc        = ex_ctrl.alu_src;
    assign exBranch        = ex_ctrl.branch;
    assign exJump          = ex_ctrl.jump;
    assign exAluOp         = ex_ctrl.alu_op;
    assign exImmediate     = ex_ctrl.immediate;
    assign exPc            = ex_pc;
    assign exIllegal       = ex_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, checked by a
// transaction-level model and a scoreboard queue drained by a monitor.
module tb_decode_stage;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic        alu_src;
        logic        br;
        logic        jp;
        logic [3:0]  aluop;
        logic        ill;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inInstr = '0;
    logic [31:0] inPc = '0;
    logic        flush = 1'b0;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic        exValid;
    logic        exReady = 1'b0;
    logic [4:0]  exWriteRegister;
    logic        exRegWrite, exMemRead, exMemWrite, exAluSrc, exBranch, exJump;
    logic [3:0]  exAluOp;
    logic [31:0] exImmediate;
    logic [31:0] exPc;
    logic        exIllegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic m_valid = 1'b0;
    logic [4:0] m_load_dest = '0;
    logic mon_en = 1'b0;

    decode_stage dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .inInstr(inInstr), .inPc(inPc), .flush(flush),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .exValid(exValid), .exReady(exReady), .exWriteRegister(exWriteRegister),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exAluSrc(exAluSrc), .exBranch(exBranch), .exJump(exJump),
        .exAluOp(exAluOp), .exImmediate(exImmediate), .exPc(exPc),
        .exIllegal(exIllegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t dut_pack();
        exp_t d;
        d = {exRegWrite, exMemRead, exMemWrite, exAluSrc, exBranch, exJump,
             exAluOp, exIllegal, exWriteRegister, exImmediate, exPc};
        return d;
    endfunction

    // Reference decode: mnemonic lookup, then the architectural meaning of each.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t  e;
        string m;
        logic [5:0] op;
        op = ins[31:26];
        e = '0;
        e.pc  = pc;
        e.wr  = (op == 6'h00) ? ins[15:11] : ins[20:16];
        e.imm = (op == 6'h02) ? {4'b0, ins[25:0], 2'b0} : {{16{ins[15]}}, ins[15:0]};
        if (op == 6'h00) begin
            case (ins[5:0])
                6'h20: m = "add";
                6'h22: m = "sub";
                6'h24: m = "and";
                6'h25: m = "or";
                6'h2A: m = "slt";
                default: m = "bad";
            endcase
        end else begin
            case (op)
                6'h08: m = "addi";
                6'h23: m = "lw";
                6'h2B: m = "sw";
                6'h04: m = "beq";
                6'h02: m = "j";
                default: m = "bad";
            endcase
        end
        case (m)
            "add":  begin e.rw = 1; e.aluop = 0; end
            "sub":  begin e.rw = 1; e.aluop = 1; end
            "and":  begin e.rw = 1; e.aluop = 2; end
            "or":   begin e.rw = 1; e.aluop = 3; end
            "slt":  begin e.rw = 1; e.aluop = 4; end
            "addi": begin e.rw = 1; e.alu_src = 1; end
            "lw":   begin e.rw = 1; e.mr = 1; e.alu_src = 1; end
            "sw":   begin e.mw = 1; e.alu_src = 1; end
            "beq":  begin e.br = 1; e.aluop = 1; end
            "j":    e.jp = 1;
            default: e.ill = TRAP;
        endcase
        if (e.wr == 0) e.rw = 0;
        return e;
    endfunction

    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] d);
        logic [5:0] op;
        op = ins[31:26];
        return (op != 6'h02 && ins[25:21] == d) ||
               ((op == 6'h00 || op == 6'h2B || op == 6'h04) && ins[20:16] == d);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int k;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        k   = $urandom_range(0, 11);
        case (k)
            0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, 5'd0, fns[k]};
            5:  return {6'h08, rs, rt, imm};
            6:  return {6'h23, rs, rt, imm};
            7:  return {6'h2B, rs, rt, imm};
            8:  return {6'h04, rs, rt, imm};
            9:  return {6'h02, 26'($urandom)};
            10: return {6'h3F, rs, rt, imm};
            default: return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
        endcase
    endfunction

    // One clock of stimulus; the model predicts acceptance and the next ID/EX state.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic adv, hz, exp_rdy, acc, nv;
        logic [4:0] nld;
        exp_t e;
        @(negedge clk);
        inValid = v; inInstr = ins; inPc = pc; exReady = rdy; flush = fl;
        #1;
        adv     = !m_valid || rdy;
        hz      = m_valid && m_load_dest != 0 && reads_reg(ins, m_load_dest);
        exp_rdy = adv && !hz && !fl;
        chk("in_ready", inReady, exp_rdy);
        chk("read_reg1", readRegister1, ins[25:21]);
        chk("read_reg2", readRegister2, ins[20:16]);
        acc = v && exp_rdy;
        e   = ref_decode(ins, pc);
        if (acc) exp_q.push_back(e);
        nv = m_valid; nld = m_load_dest;
        if (fl) begin
            if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
            nv = 0; nld = 0;
        end else if (adv) begin
            nv  = acc;
            nld = (acc && e.mr) ? e.wr : 5'd0;
        end
        @(posedge clk);
        m_valid = nv; m_load_dest = nld;
    endtask

    task automatic reset_pulse();
        #2;
        inValid = 0;
        resetN  = 0;
        #1;
        chk("reset_ex_valid", exValid, 1'b0);
        chk("reset_ex_fields", dut_pack(), '0);
        chk("reset_read_reg1", readRegister1, inInstr[25:21]);
        exp_q.delete();
        m_valid = 0; m_load_dest = 0;
        @(negedge clk);
        resetN = 1;
    endtask

    // Monitor: checks exValid every cycle and pops the scoreboard on each consumption.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("ex_valid", exValid, m_valid);
                if (exValid && exReady && !flush) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboard_empty actual=consumed expected=nothing");
                    end else begin
                        e = exp_q.pop_front();
                        chk("ex_fields", dut_pack(), e);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        chk("init_ex_valid", exValid, 1'b0);
        chk("init_ex_fields", dut_pack(), '0);
        @(negedge clk);
        resetN = 1;
        mon_en = 1;

        cycle(1, 32'h00221820, 32'h100, 1, 0);   // add $3,$1,$2
        cycle(1, 32'h8C25FFFC, 32'h104, 1, 0);   // lw $5,-4($1)
        cycle(1, 32'h00A03020, 32'h108, 1, 0);   // add $6,$5,$0 stalls
        cycle(1, 32'h00A03020, 32'h108, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(1, 32'h20430007, 32'h10C, 1, 0);   // addi, then held under exReady=0
        for (int i = 0; i < 3; i++) cycle(1, 32'hAC620010, 32'h110, 0, 0);
        cycle(1, 32'hAC620010, 32'h110, 1, 0);
        cycle(1, 32'h10220003, 32'h114, 1, 0);   // beq, then flushed
        cycle(1, 32'h08000040, 32'h118, 1, 1);
        cycle(1, 32'hFC000000, 32'h11C, 1, 0);   // opcode 0x3F
        cycle(1, 32'h0800ABCD, 32'h120, 0, 0);   // j held behind the illegal one
        cycle(1, 32'h0800ABCD, 32'h120, 1, 0);
        cycle(1, 32'h00221820, 32'h124, 0, 0);
        reset_pulse();

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 8, rand_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            if (i == 1000) reset_pulse();
        end
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
